// File: rtl/fifo_axis_drain_if.sv
// rtl/fifo_axis_drain_if.sv - FIFO read port and outbound beat stream bundle for fifo_axis_drain.
interface fifo_axis_drain_if #(
  parameter int DATA_W = 128
);
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              flush_burst;

  modport master (
    output fifo_rd_en, m_valid, m_data, m_last,
    input  fifo_rd_data, fifo_empty, m_ready, flush_burst
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, m_last,
    output fifo_rd_data, fifo_empty, m_ready, flush_burst
  );
endinterface

// File: rtl/fifo_axis_drain.sv
// rtl/fifo_axis_drain.sv - FIFO read drain with 2-entry skid buffer and burst framing.
// Optional accepted-beat counter port beat_total under FIFO_DRAIN_BEAT_CNT_EN.
module fifo_axis_drain #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  fifo_axis_drain_if.master bus
`ifdef FIFO_DRAIN_BEAT_CNT_EN
  ,
  output logic [31:0]       beat_total
`endif
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ;
  logic              pend;
  logic              flush_pend;
  logic [CNT_W-1:0]  beat_cnt;
  logic              pop;
  logic              last_beat;
  logic [OCC_W:0]    committed;

  // committed counts entries that will be held after this edge, including the read in flight
  always_comb begin
    pop       = 1'b0;
    committed = '0;
    pop       = bus.m_valid && bus.m_ready;
    committed = {1'b0, occ} + {{OCC_W{1'b0}}, pend} - {{OCC_W{1'b0}}, pop};
  end

  assign bus.m_valid    = (occ != '0);
  assign last_beat      = (beat_cnt == CNT_W'(BURST_LEN - 1)) || flush_pend;
  assign bus.m_last     = bus.m_valid && last_beat;
  assign bus.m_data     = mem[rd_ptr];
  assign bus.fifo_rd_en = !rst && !bus.fifo_empty && (committed < (OCC_W + 1)'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= '0;
      pend       <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pend <= bus.fifo_rd_en;
      if (pend) begin
        mem[wr_ptr] <= bus.fifo_rd_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        beat_cnt <= bus.m_last ? '0 : beat_cnt + 1'b1;
      end
      occ <= occ + OCC_W'(pend) - OCC_W'(pop);
      // A non-last pop opens a burst this edge, so a coincident flush still closes it
      if (pop && bus.m_last) begin
        flush_pend <= 1'b0;
      end else if (bus.flush_burst && ((beat_cnt != '0) || pop)) begin
        flush_pend <= 1'b1;
      end
    end
  end

`ifdef FIFO_DRAIN_BEAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_total <= '0;
    end else if (pop) begin
      beat_total <= beat_total + 32'd1;
    end
  end
`endif

endmodule
